// File: rtl/ex_muldiv_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit_if
// Purpose  : Bundle of the ID/EX-side request signals and the EX-stage result
//            signals of the iterative RV32M multiply/divide unit.
// Signals  : IN_VALID, IN_ALU_OP[4:0], IN_DATA1[31:0], IN_DATA2[31:0],
//            IN_RD[4:0], KILL                      (pipeline -> unit)
//            STALL, OUT_RESULT[31:0], OUT_RD[4:0],
//            OUT_VALID                             (unit -> pipeline)
// Modports : master = pipeline side, slave = multiply/divide unit
// Revision : 1.0  initial release
// ============================================================================
interface ex_muldiv_unit_if;
  logic        IN_VALID;
  logic [4:0]  IN_ALU_OP;
  logic [31:0] IN_DATA1;
  logic [31:0] IN_DATA2;
  logic [4:0]  IN_RD;
  logic        KILL;
  logic        STALL;
  logic [31:0] OUT_RESULT;
  logic [4:0]  OUT_RD;
  logic        OUT_VALID;

  modport master (
    output IN_VALID, IN_ALU_OP, IN_DATA1, IN_DATA2, IN_RD, KILL,
    input  STALL, OUT_RESULT, OUT_RD, OUT_VALID
  );

  modport slave (
    input  IN_VALID, IN_ALU_OP, IN_DATA1, IN_DATA2, IN_RD, KILL,
    output STALL, OUT_RESULT, OUT_RD, OUT_VALID
  );
endinterface
`default_nettype wire

// File: rtl/ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv_unit
// Purpose  : Iterative RV32M multiply/divide unit for the execute stage.
//            32-cycle shift-add multiplier and restoring divider sharing one
//            64-bit accumulator; divide-by-zero and signed overflow are
//            resolved at start without iterating.
// Ports    : CLK  rising-edge clock
//            RST  synchronous active-high reset
//            bus  ex_muldiv_unit_if.slave (request in, STALL/result out)
// Revision : 1.0  initial release
// ============================================================================
module ex_muldiv_unit (
  input  wire logic        CLK,
  input  wire logic        RST,
  ex_muldiv_unit_if.slave  bus
);

  // Low three op-code bits once the 5'b10xxx group has been confirmed
  localparam logic [2:0] c_MUL    = 3'd0;
  localparam logic [2:0] c_MULH   = 3'd1;
  localparam logic [2:0] c_MULHSU = 3'd2;
  localparam logic [2:0] c_DIV    = 3'd4;
  localparam logic [2:0] c_REM    = 3'd6;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  logic [4:0]  r_cnt;
  logic [2:0]  r_op;
  logic [4:0]  r_rd;
  logic [31:0] r_opnd;     // multiplicand or divisor magnitude
  logic [63:0] r_acc;      // {partial product | remainder, multiplier | dividend/quotient}
  logic        r_neg_q;    // product / quotient sign
  logic        r_neg_r;    // remainder sign
  logic [31:0] r_result;
  logic [4:0]  r_out_rd;

  // ---------------- start decode ----------------
  logic [2:0]  w_op;
  logic        w_start, w_is_div, w_sgn_a, w_sgn_b, w_neg_a, w_neg_b;
  logic        w_div0, w_ovf;
  logic [31:0] w_mag_a, w_mag_b, w_special;

  assign w_op     = bus.IN_ALU_OP[2:0];
  assign w_start  = (r_state == S_IDLE) && bus.IN_VALID &&
                    (bus.IN_ALU_OP[4:3] == 2'b10) && !bus.KILL;
  assign w_is_div = w_op[2];
  assign w_sgn_a  = (w_op == c_MUL) || (w_op == c_MULH) || (w_op == c_MULHSU) ||
                    (w_op == c_DIV) || (w_op == c_REM);
  assign w_sgn_b  = (w_op == c_MUL) || (w_op == c_MULH) ||
                    (w_op == c_DIV) || (w_op == c_REM);
  assign w_neg_a  = w_sgn_a && bus.IN_DATA1[31];
  assign w_neg_b  = w_sgn_b && bus.IN_DATA2[31];
  assign w_mag_a  = w_neg_a ? (32'd0 - bus.IN_DATA1) : bus.IN_DATA1;
  assign w_mag_b  = w_neg_b ? (32'd0 - bus.IN_DATA2) : bus.IN_DATA2;
  assign w_div0   = w_is_div && (bus.IN_DATA2 == 32'd0);
  assign w_ovf    = ((w_op == c_DIV) || (w_op == c_REM)) &&
                    (bus.IN_DATA1 == 32'h8000_0000) && (bus.IN_DATA2 == 32'hFFFF_FFFF);
  // op[1] selects the remainder flavour within the divide group
  assign w_special = w_div0 ? (w_op[1] ? bus.IN_DATA1 : 32'hFFFF_FFFF)
                            : (w_op[1] ? 32'd0        : 32'h8000_0000);

  // ---------------- iteration step ----------------
  logic [32:0] w_add, w_rsh, w_diff;
  logic [63:0] w_mul_next, w_div_next, w_prod;
  logic [31:0] w_quo, w_rem, w_final;

  // Multiply: conditional add into the upper half, then shift right
  assign w_add      = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opnd} : 33'd0);
  assign w_mul_next = {w_add, r_acc[31:1]};

  // Divide: shift the next dividend bit into the remainder, trial-subtract;
  // a set borrow bit means the trial failed and the remainder is kept
  assign w_rsh      = r_acc[63:31];
  assign w_diff     = w_rsh - {1'b0, r_opnd};
  assign w_div_next = w_diff[32] ? {w_rsh[31:0],  r_acc[30:0], 1'b0}
                                 : {w_diff[31:0], r_acc[30:0], 1'b1};

  // Sign correction applied to the value produced by the last step
  assign w_prod = r_neg_q ? (64'd0 - w_mul_next) : w_mul_next;
  assign w_quo  = r_neg_q ? (32'd0 - w_div_next[31:0])  : w_div_next[31:0];
  assign w_rem  = r_neg_r ? (32'd0 - w_div_next[63:32]) : w_div_next[63:32];

  always_comb begin
    w_final = w_prod[63:32];
    case (r_op)
      c_MUL:        w_final = w_prod[31:0];
      3'd4, 3'd5:   w_final = w_quo;
      3'd6, 3'd7:   w_final = w_rem;
      default:      w_final = w_prod[63:32];
    endcase
  end

  // ---------------- control ----------------
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state  <= S_IDLE;
      r_cnt    <= 5'd0;
      r_op     <= 3'd0;
      r_rd     <= 5'd0;
      r_opnd   <= 32'd0;
      r_acc    <= 64'd0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
      r_result <= 32'd0;
      r_out_rd <= 5'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_op  <= w_op;
            r_rd  <= bus.IN_RD;
            r_cnt <= 5'd0;
            if (w_div0 || w_ovf) begin
              r_result <= w_special;
              r_out_rd <= bus.IN_RD;
              r_state  <= S_DONE;
            end else begin
              r_opnd  <= w_is_div ? w_mag_b : w_mag_a;
              r_acc   <= {32'd0, (w_is_div ? w_mag_a : w_mag_b)};
              r_neg_q <= w_neg_a ^ w_neg_b;
              r_neg_r <= w_neg_a;
              r_state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (bus.KILL) begin
            r_cnt   <= 5'd0;
            r_state <= S_IDLE;
          end else begin
            r_acc <= r_op[2] ? w_div_next : w_mul_next;
            r_cnt <= r_cnt + 5'd1;
            if (r_cnt == 5'd31) begin
              r_result <= w_final;
              r_out_rd <= r_rd;
              r_state  <= S_DONE;
            end
          end
        end
        // ID/EX still holds the finished instruction here; never restart
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.STALL      = !RST && (w_start || (r_state == S_CALC));
  assign bus.OUT_VALID  = (r_state == S_DONE) && !bus.KILL;
  assign bus.OUT_RESULT = r_result;
  assign bus.OUT_RD     = r_out_rd;

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_ex_muldiv_unit
// Purpose  : Self-checking bench for ex_muldiv_unit. A cycle-level reference
//            model built from plain 64-bit arithmetic predicts STALL,
//            OUT_VALID, OUT_RESULT and OUT_RD every cycle; directed vectors
//            add literal expectations for results, stall length and spacing.
// Revision : 1.0  initial release
// ============================================================================
module tb_ex_muldiv_unit;

  logic clk = 1'b0;
  logic rst;
  ex_muldiv_unit_if dif();

  ex_muldiv_unit dut (
    .CLK (clk),
    .RST (rst),
    .bus (dif)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- reference arithmetic ----------------
  function automatic logic [31:0] ref_result(input logic [4:0] op, input logic [31:0] a,
                                             input logic [31:0] b);
    longint          sa, sb;
    longint unsigned ua, ub;
    logic [63:0]     p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      5'h10: begin p = sa * sb;            return p[31:0];  end
      5'h11: begin p = sa * sb;            return p[63:32]; end
      5'h12: begin p = sa * longint'(ub);  return p[63:32]; end
      5'h13: begin p = ua * ub;            return p[63:32]; end
      5'h14: begin if (b == 0) return 32'hFFFF_FFFF; p = sa / sb; return p[31:0]; end
      5'h15: begin if (b == 0) return 32'hFFFF_FFFF; p = ua / ub; return p[31:0]; end
      5'h16: begin if (b == 0) return a;             p = sa % sb; return p[31:0]; end
      default: begin if (b == 0) return a;           p = ua % ub; return p[31:0]; end
    endcase
  endfunction

  // Cycles from the start edge to the DONE cycle
  function automatic int ref_lat(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op >= 5'h14 && b == 32'd0) return 1;
    if ((op == 5'h14 || op == 5'h16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // ---------------- model state and observations ----------------
  bit          m_busy = 1'b0;
  int          m_done = 0;
  logic [31:0] m_new_res, m_hold_res;
  logic [4:0]  m_new_rd, m_hold_rd;
  logic [31:0] last_res = 32'd0;
  logic [4:0]  last_rd = 5'd0;
  int          last_vcyc = 0;
  int          vcnt = 0;
  int          stall_cnt = 0;

  always @(negedge clk) begin
    logic sc, ev, es;
    if (rst) begin
      check("stall_in_reset", {31'd0, dif.STALL}, 32'd0);
      m_busy     = 1'b0;
      m_hold_res = 32'd0;
      m_hold_rd  = 5'd0;
    end else begin
      sc = dif.IN_VALID && dif.IN_ALU_OP >= 5'h10 && dif.IN_ALU_OP <= 5'h17 && !dif.KILL;
      if (m_busy && cyc == m_done) begin
        m_hold_res = m_new_res;
        m_hold_rd  = m_new_rd;
      end
      ev = m_busy && cyc == m_done && !dif.KILL;
      es = (m_busy && cyc < m_done) || (!m_busy && sc);
      check("stall",  {31'd0, dif.STALL},     {31'd0, es});
      check("valid",  {31'd0, dif.OUT_VALID}, {31'd0, ev});
      check("result", dif.OUT_RESULT,         m_hold_res);
      check("rd",     {27'd0, dif.OUT_RD},    {27'd0, m_hold_rd});
      if (dif.STALL) stall_cnt++;
      if (dif.OUT_VALID) begin
        last_res  = dif.OUT_RESULT;
        last_rd   = dif.OUT_RD;
        last_vcyc = cyc;
        vcnt++;
      end
      if (m_busy) begin
        if (cyc == m_done || dif.KILL) m_busy = 1'b0;
      end else if (sc) begin
        m_busy    = 1'b1;
        m_done    = cyc + ref_lat(dif.IN_ALU_OP, dif.IN_DATA1, dif.IN_DATA2);
        m_new_res = ref_result(dif.IN_ALU_OP, dif.IN_DATA1, dif.IN_DATA2);
        m_new_rd  = dif.IN_RD;
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    dif.IN_VALID  = 1'b1;
    dif.IN_ALU_OP = op;
    dif.IN_DATA1  = a;
    dif.IN_DATA2  = b;
    dif.IN_RD     = rd;
  endtask

  // Hold the instruction in ID/EX through DONE, then let it advance
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd);
    int edges;
    edges = (op >= 5'h14 && b == 32'd0) ||
            ((op == 5'h14 || op == 5'h16) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 2 : 34;
    drive(op, a, b, rd);
    repeat (edges) tick();
    dif.IN_VALID = 1'b0;
  endtask

  task automatic expect_op(input string name, input logic [4:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] rd,
                           input logic [31:0] exp_res, input int exp_stall);
    int s0, v0;
    s0 = stall_cnt;
    v0 = vcnt;
    issue(op, a, b, rd);
    check({name, "_res"},   last_res, exp_res);
    check({name, "_rd"},    {27'd0, last_rd}, {27'd0, rd});
    check({name, "_stall"}, 32'(stall_cnt - s0), 32'(exp_stall));
    check({name, "_pulse"}, 32'(vcnt - v0), 32'd1);
  endtask

  initial begin
    int v1, vc;
    rst           = 1'b1;
    dif.IN_VALID  = 1'b0;
    dif.IN_ALU_OP = 5'h00;
    dif.IN_DATA1  = 32'd0;
    dif.IN_DATA2  = 32'd0;
    dif.IN_RD     = 5'd0;
    dif.KILL      = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    tick();
    check("reset_result", dif.OUT_RESULT, 32'd0);
    check("reset_rd",     {27'd0, dif.OUT_RD},  32'd0);
    check("reset_valid",  {31'd0, dif.OUT_VALID}, 32'd0);
    check("reset_stall",  {31'd0, dif.STALL}, 32'd0);

    // Multiply family
    expect_op("mul",    5'h10, 32'd7,         32'hFFFF_FFFD, 5'd5,  32'hFFFF_FFEB, 33);
    expect_op("mulh",   5'h11, 32'h8000_0000, 32'h8000_0000, 5'd6,  32'h4000_0000, 33);
    expect_op("mulhu",  5'h13, 32'h8000_0000, 32'h8000_0000, 5'd7,  32'h4000_0000, 33);
    expect_op("mulhsu", 5'h12, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'hC000_0000, 33);
    tick();

    // DIVU then REMU back to back
    expect_op("divu", 5'h15, 32'd100, 32'd7, 5'd9, 32'd14, 33);
    v1 = last_vcyc;
    expect_op("remu", 5'h17, 32'd100, 32'd7, 5'd10, 32'd2, 33);
    check("divu_remu_spacing", 32'(last_vcyc - v1), 32'd34);
    tick();

    // Special cases, back to back
    expect_op("div0", 5'h14, 32'd5, 32'd0, 5'd11, 32'hFFFF_FFFF, 1);
    v1 = last_vcyc;
    expect_op("rem0", 5'h16, 32'd5, 32'd0, 5'd12, 32'd5, 1);
    check("special_spacing", 32'(last_vcyc - v1), 32'd2);
    expect_op("divovf", 5'h14, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);
    expect_op("removf", 5'h16, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'd0, 1);
    tick();

    // Signed divide
    expect_op("div_neg", 5'h14, 32'hFFFF_FFF9, 32'd2, 5'd15, 32'hFFFF_FFFD, 33);
    expect_op("rem_neg", 5'h16, 32'hFFFF_FFF9, 32'd2, 5'd16, 32'hFFFF_FFFF, 33);
    tick();

    // KILL at CALC count 10
    vc = vcnt;
    drive(5'h15, 32'd1000, 32'd3, 5'd17);
    tick();                      // start edge; now count 0
    repeat (10) tick();          // now count 10
    dif.KILL = 1'b1;
    tick();
    dif.KILL     = 1'b0;
    dif.IN_VALID = 1'b0;
    check("kill_stall",  {31'd0, dif.STALL}, 32'd0);
    check("kill_result", dif.OUT_RESULT, 32'hFFFF_FFFF);
    repeat (40) tick();
    check("kill_no_valid", 32'(vcnt - vc), 32'd0);

    // KILL together with a start in IDLE: not accepted
    drive(5'h10, 32'd3, 32'd4, 5'd18);
    dif.KILL = 1'b1;
    tick();
    dif.KILL     = 1'b0;
    dif.IN_VALID = 1'b0;
    repeat (40) tick();
    check("kill_idle_no_start", 32'(vcnt - vc), 32'd0);

    // KILL in DONE masks the strobe
    drive(5'h14, 32'd9, 32'd0, 5'd19);
    tick();                      // start edge; now DONE
    dif.KILL = 1'b1;
    tick();
    dif.KILL     = 1'b0;
    dif.IN_VALID = 1'b0;
    tick();
    check("kill_done_masked", 32'(vcnt - vc), 32'd0);

    // Reset at count 20
    drive(5'h10, 32'd123, 32'd456, 5'd20);
    tick();
    repeat (20) tick();
    rst          = 1'b1;
    dif.IN_VALID = 1'b0;
    tick();
    check("rst_mid_result", dif.OUT_RESULT, 32'd0);
    check("rst_mid_rd",     {27'd0, dif.OUT_RD}, 32'd0);
    check("rst_mid_valid",  {31'd0, dif.OUT_VALID}, 32'd0);
    check("rst_mid_stall",  {31'd0, dif.STALL}, 32'd0);
    rst = 1'b0;
    tick();
    expect_op("post_rst_mulhu", 5'h13, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd21, 32'hFFFF_FFFE, 33);
    repeat (3) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
